// File: rtl/wishbone_cmd_master.sv
// ============================================================================
// wishbone_cmd_master : single-outstanding Wishbone classic master with timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module wishbone_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic        clk48,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [29:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [29:0] wishbone_adr,
  output logic [31:0] wishbone_datwr,
  input  logic [31:0] wishbone_datrd,
  output logic [3:0]  wishbone_sel,
  output logic        wishbone_cyc,
  output logic        wishbone_stb,
  output logic        wishbone_we,
  output logic [2:0]  wishbone_cti,
  output logic [1:0]  wishbone_bte,
  input  logic        wishbone_ack,
  input  logic        wishbone_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // A zero timeout disables the abort path entirely.
  localparam bit              c_to_en   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] c_to_last = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [TO_W-1:0] r_cnt;
  logic [29:0]     r_adr;
  logic [31:0]     r_datwr;
  logic [3:0]      r_sel;
  logic            r_we;
  logic [31:0]     r_rsp_dat;
  logic            r_rsp_err;
  logic            r_rsp_to;
  logic            w_accept;
  logic            w_to_hit;
  logic            w_bus_end;

  assign w_accept  = cmd_valid & cmd_ready;
  assign w_to_hit  = c_to_en && (r_cnt == c_to_last) && !wishbone_ack && !wishbone_err;
  assign w_bus_end = wishbone_ack | wishbone_err | w_to_hit;

  always_ff @(posedge clk48) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_BUS;
      S_BUS:   if (w_bus_end) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = (r_state == S_IDLE) & ~reset;
    wishbone_cyc = (r_state == S_BUS);
    wishbone_stb = (r_state == S_BUS);
    rsp_valid    = (r_state == S_RESP);
    busy         = (r_state != S_IDLE);
  end

  always_ff @(posedge clk48) begin
    if (reset) begin
      r_adr     <= '0;
      r_datwr   <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
      r_rsp_to  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_adr   <= cmd_adr;
        r_datwr <= cmd_dat;
        r_sel   <= cmd_sel;
        r_we    <= cmd_we;
        r_cnt   <= '0;
      end else if (r_state == S_BUS) begin
        r_cnt <= r_cnt + TO_W'(1);
      end
      // Error beats ack; only a clean read ack returns data.
      if ((r_state == S_BUS) && w_bus_end) begin
        r_rsp_err <= wishbone_err | w_to_hit;
        r_rsp_to  <= w_to_hit;
        r_rsp_dat <= (wishbone_ack && !wishbone_err && !r_we) ? wishbone_datrd : 32'd0;
      end
    end
  end

  assign wishbone_adr   = r_adr;
  assign wishbone_datwr = r_datwr;
  assign wishbone_sel   = r_sel;
  assign wishbone_we    = r_we;
  assign wishbone_cti   = 3'b000;
  assign wishbone_bte   = 2'b00;
  assign rsp_dat        = r_rsp_dat;
  assign rsp_err        = r_rsp_err;
  assign rsp_timeout    = r_rsp_to;

endmodule

`default_nettype wire

// File: tb/tb_wishbone_cmd_master.sv
// ============================================================================
// tb_wishbone_cmd_master : directed self-checking bench for wishbone_cmd_master
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wishbone_cmd_master;

  logic        clk48 = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [29:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [29:0] wishbone_adr;
  logic [31:0] wishbone_datwr;
  logic [31:0] wishbone_datrd;
  logic [3:0]  wishbone_sel;
  logic        wishbone_cyc;
  logic        wishbone_stb;
  logic        wishbone_we;
  logic [2:0]  wishbone_cti;
  logic [1:0]  wishbone_bte;
  logic        wishbone_ack;
  logic        wishbone_err;

  int r_checks   = 0;
  int r_failures = 0;

  wishbone_cmd_master #(
    .TIMEOUT_CYCLES(8),
    .TO_W          (4)
  ) u_dut (
    .clk48          (clk48),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_we         (cmd_we),
    .cmd_adr        (cmd_adr),
    .cmd_dat        (cmd_dat),
    .cmd_sel        (cmd_sel),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_dat        (rsp_dat),
    .rsp_err        (rsp_err),
    .rsp_timeout    (rsp_timeout),
    .busy           (busy),
    .wishbone_adr   (wishbone_adr),
    .wishbone_datwr (wishbone_datwr),
    .wishbone_datrd (wishbone_datrd),
    .wishbone_sel   (wishbone_sel),
    .wishbone_cyc   (wishbone_cyc),
    .wishbone_stb   (wishbone_stb),
    .wishbone_we    (wishbone_we),
    .wishbone_cti   (wishbone_cti),
    .wishbone_bte   (wishbone_bte),
    .wishbone_ack   (wishbone_ack),
    .wishbone_err   (wishbone_err)
  );

  always #5 clk48 = ~clk48;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  // Present a command, expect it accepted, and check the bus drive one edge later.
  task automatic send_cmd(input string tag, input logic we, input logic [29:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input bit keep_valid);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    chk({tag, " cmd_ready before accept"}, cmd_ready, 1'b1);
    tick();
    if (!keep_valid) cmd_valid = 1'b0;
    chk({tag, " cyc after accept"}, wishbone_cyc, 1'b1);
    chk({tag, " stb equals cyc"}, wishbone_stb, wishbone_cyc);
    chk({tag, " adr"}, wishbone_adr, adr);
    chk({tag, " we"}, wishbone_we, we);
    chk({tag, " sel"}, wishbone_sel, sel);
    if (we) chk({tag, " datwr"}, wishbone_datwr, dat);
    chk({tag, " cmd_ready while busy"}, cmd_ready, 1'b0);
  endtask

  // Play the slave: respond on stb cycle number resp_at (0 = stay silent).
  task automatic slave_run(input int resp_at, input logic do_ack, input logic do_err,
                           input logic [31:0] rdata, output int ncyc);
    ncyc = 0;
    while (wishbone_cyc && ncyc < 64) begin
      ncyc++;
      if (ncyc == resp_at) begin
        wishbone_ack   = do_ack;
        wishbone_err   = do_err;
        wishbone_datrd = rdata;
      end
      tick();
      wishbone_ack = 1'b0;
      wishbone_err = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen_rsp;
    reset          = 1'b1;
    cmd_valid      = 1'b0;
    cmd_we         = 1'b0;
    cmd_adr        = '0;
    cmd_dat        = '0;
    cmd_sel        = '0;
    rsp_ready      = 1'b0;
    wishbone_datrd = '0;
    wishbone_ack   = 1'b0;
    wishbone_err   = 1'b0;
    repeat (3) tick();
    chk("reset cmd_ready low while reset", cmd_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset cyc", wishbone_cyc, 1'b0);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset rsp_dat", rsp_dat, 32'd0);
    chk("reset rsp_err", rsp_err, 1'b0);
    chk("reset adr", wishbone_adr, 30'd0);
    chk("cti", wishbone_cti, 3'b000);
    chk("bte", wishbone_bte, 2'b00);

    // Write, slave acks on the third stb cycle.
    send_cmd("wr", 1'b1, 30'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0);
    slave_run(3, 1'b1, 1'b0, 32'hFFFF_FFFF, n);
    chk("wr cyc cycles", n, 3);
    chk("wr rsp_valid", rsp_valid, 1'b1);
    chk("wr rsp_err", rsp_err, 1'b0);
    chk("wr rsp_timeout", rsp_timeout, 1'b0);
    chk("wr rsp_dat", rsp_dat, 32'd0);
    chk("wr busy in resp", busy, 1'b1);
    rsp_ready = 1'b1;
    tick();
    chk("wr rsp_valid after handshake", rsp_valid, 1'b0);
    chk("wr back to idle", cmd_ready, 1'b1);

    // Read with ack in the first stb cycle: response two edges after accept.
    send_cmd("rd", 1'b0, 30'h0000_0204, 32'h0BAD_0BAD, 4'h3, 1'b0);
    slave_run(1, 1'b1, 1'b0, 32'h1234_5678, n);
    chk("rd cyc cycles", n, 1);
    chk("rd rsp_valid latency", rsp_valid, 1'b1);
    chk("rd rsp_dat", rsp_dat, 32'h1234_5678);
    chk("rd rsp_err", rsp_err, 1'b0);
    tick();
    chk("rd rsp_valid falls", rsp_valid, 1'b0);

    // err together with ack: err wins, data zeroed.
    send_cmd("err", 1'b0, 30'h0000_0300, 32'd0, 4'hF, 1'b0);
    slave_run(1, 1'b1, 1'b1, 32'hFFFF_FFFF, n);
    chk("err rsp_valid", rsp_valid, 1'b1);
    chk("err rsp_err", rsp_err, 1'b1);
    chk("err rsp_timeout", rsp_timeout, 1'b0);
    chk("err rsp_dat", rsp_dat, 32'd0);
    tick();

    // Silent slave: abort after exactly 8 stb cycles.
    rsp_ready = 1'b0;
    send_cmd("to", 1'b0, 30'h0000_0400, 32'd0, 4'hF, 1'b0);
    slave_run(0, 1'b0, 1'b0, 32'd0, n);
    chk("to cyc cycles", n, 8);
    chk("to rsp_valid", rsp_valid, 1'b1);
    chk("to rsp_err", rsp_err, 1'b1);
    chk("to rsp_timeout", rsp_timeout, 1'b1);
    chk("to rsp_dat", rsp_dat, 32'd0);
    wishbone_ack   = 1'b1;
    wishbone_datrd = 32'h5555_5555;
    tick();
    wishbone_ack = 1'b0;
    chk("late ack in resp rsp_timeout", rsp_timeout, 1'b1);
    chk("late ack in resp rsp_dat", rsp_dat, 32'd0);
    chk("late ack in resp cyc", wishbone_cyc, 1'b0);
    rsp_ready = 1'b1;
    tick();
    wishbone_ack = 1'b1;
    tick();
    wishbone_ack = 1'b0;
    chk("late ack in idle cyc", wishbone_cyc, 1'b0);
    chk("late ack in idle rsp_valid", rsp_valid, 1'b0);
    send_cmd("after to", 1'b0, 30'h0000_0500, 32'd0, 4'hC, 1'b0);
    slave_run(2, 1'b1, 1'b0, 32'hCAFE_F00D, n);
    chk("after to cyc cycles", n, 2);
    chk("after to rsp_dat", rsp_dat, 32'hCAFE_F00D);
    chk("after to rsp_err", rsp_err, 1'b0);
    chk("after to rsp_timeout", rsp_timeout, 1'b0);
    tick();

    // Backpressure with cmd_valid held high throughout.
    rsp_ready = 1'b0;
    send_cmd("bp", 1'b0, 30'h0000_0600, 32'd0, 4'hF, 1'b1);
    slave_run(1, 1'b1, 1'b0, 32'hA5A5_5A5A, n);
    for (int i = 0; i < 5; i++) begin
      chk("bp rsp_valid", rsp_valid, 1'b1);
      chk("bp rsp_dat", rsp_dat, 32'hA5A5_5A5A);
      chk("bp cmd_ready", cmd_ready, 1'b0);
      chk("bp cyc", wishbone_cyc, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp rsp_valid after handshake", rsp_valid, 1'b0);
    chk("bp cmd_ready after handshake", cmd_ready, 1'b1);
    cmd_valid = 1'b0;
    tick();
    chk("bp no stray accept", wishbone_cyc, 1'b0);

    // Reset in the middle of a bus cycle drops everything.
    send_cmd("rst", 1'b1, 30'h0000_0700, 32'h1111_2222, 4'h1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst cyc", wishbone_cyc, 1'b0);
    chk("rst stb", wishbone_stb, 1'b0);
    seen_rsp = 1'b0;
    wishbone_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      wishbone_ack = 1'b0;
      if (rsp_valid) seen_rsp = 1'b1;
    end
    chk("rst rsp_valid never rises", seen_rsp, 1'b0);
    chk("rst cmd_ready", cmd_ready, 1'b1);
    chk("rst busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
    $finish;
  end

endmodule

`default_nettype wire
